// File: rtl/cont_bcd_mod.sv
`default_nettype none
// cont_bcd_mod: two-digit BCD modulo counter (up/down, range-checked load, wrap and load-error pulses).
// Revision 1.0 - initial release.
module cont_bcd_mod #(
   parameter int MODULO = 24,
   parameter int MSD_W  = 3
) (
   input  logic             cbcd_clock,
   input  logic             cbcd_reset,
   input  logic             cbcd_en,
   input  logic             cbcd_up,
   input  logic             cbcd_load,
   input  logic [3:0]       cbcd_load_lsd,
   input  logic [MSD_W-1:0] cbcd_load_msd,
   output logic [3:0]       cbcd_lsd,
   output logic [MSD_W-1:0] cbcd_msd,
   output logic             cbcd_wrap,
   output logic             cbcd_load_err
);

   localparam int               TOP_MSD_I = (MODULO - 1) / 10;
   localparam int               TOP_LSD_I = (MODULO - 1) % 10;
   localparam logic [MSD_W-1:0] TOP_MSD   = TOP_MSD_I[MSD_W-1:0];
   localparam logic [3:0]       TOP_LSD   = TOP_LSD_I[3:0];

   generate
      if (MODULO < 2 || MODULO > 10 * (2 ** MSD_W)) begin : g_bad_modulo
         $error("cont_bcd_mod: MODULO out of range for MSD_W");
      end
   endgenerate

   logic load_ok;
   logic at_top;
   logic at_zero;

   // Range check is done digit-wise against the top value, no binary sum needed.
   always_comb begin
      load_ok = 1'b0;
      if (cbcd_load_lsd <= 4'd9) begin
         if (cbcd_load_msd < TOP_MSD) begin
            load_ok = 1'b1;
         end else if (cbcd_load_msd == TOP_MSD && cbcd_load_lsd <= TOP_LSD) begin
            load_ok = 1'b1;
         end
      end
   end

   assign at_top  = (cbcd_msd == TOP_MSD) && (cbcd_lsd == TOP_LSD);
   assign at_zero = (cbcd_msd == '0) && (cbcd_lsd == 4'd0);

   always_ff @(posedge cbcd_clock or negedge cbcd_reset) begin
      if (!cbcd_reset) begin
         cbcd_lsd      <= 4'd0;
         cbcd_msd      <= '0;
         cbcd_wrap     <= 1'b0;
         cbcd_load_err <= 1'b0;
      end else begin
         cbcd_wrap     <= 1'b0;
         cbcd_load_err <= 1'b0;
         if (cbcd_load) begin
            if (load_ok) begin
               cbcd_lsd <= cbcd_load_lsd;
               cbcd_msd <= cbcd_load_msd;
            end else begin
               cbcd_load_err <= 1'b1;
            end
         end else if (cbcd_en) begin
            if (cbcd_up) begin
               if (at_top) begin
                  cbcd_lsd  <= 4'd0;
                  cbcd_msd  <= '0;
                  cbcd_wrap <= 1'b1;
               end else if (cbcd_lsd == 4'd9) begin
                  cbcd_lsd <= 4'd0;
                  cbcd_msd <= cbcd_msd + MSD_W'(1);
               end else begin
                  cbcd_lsd <= cbcd_lsd + 4'd1;
               end
            end else begin
               if (at_zero) begin
                  cbcd_lsd  <= TOP_LSD;
                  cbcd_msd  <= TOP_MSD;
                  cbcd_wrap <= 1'b1;
               end else if (cbcd_lsd == 4'd0) begin
                  cbcd_lsd <= 4'd9;
                  cbcd_msd <= cbcd_msd - MSD_W'(1);
               end else begin
                  cbcd_lsd <= cbcd_lsd - 4'd1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cont_bcd_mod.sv
`default_nettype none
// tb_cont_bcd_mod: scoreboard bench for cont_bcd_mod (MODULO 24, 60 and a 60/60/24 chain).
// Revision 1.0 - initial release.
module tb_cont_bcd_mod;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // MODULO=24 instance
   logic       rst24 = 1'b0, en24 = 1'b0, up24 = 1'b1, ld24 = 1'b0;
   logic [3:0] ll24 = 4'd0, lsd24;
   logic [2:0] lm24 = 3'd0, msd24;
   logic       w24, e24;

   cont_bcd_mod #(.MODULO(24), .MSD_W(3)) dut24 (
      .cbcd_clock(clk), .cbcd_reset(rst24), .cbcd_en(en24), .cbcd_up(up24),
      .cbcd_load(ld24), .cbcd_load_lsd(ll24), .cbcd_load_msd(lm24),
      .cbcd_lsd(lsd24), .cbcd_msd(msd24), .cbcd_wrap(w24), .cbcd_load_err(e24));

   // MODULO=60 instance
   logic       rst60 = 1'b0, en60 = 1'b0, up60 = 1'b1, ld60 = 1'b0;
   logic [3:0] ll60 = 4'd0, lsd60;
   logic [2:0] lm60 = 3'd0, msd60;
   logic       w60, e60;

   cont_bcd_mod #(.MODULO(60), .MSD_W(3)) dut60 (
      .cbcd_clock(clk), .cbcd_reset(rst60), .cbcd_en(en60), .cbcd_up(up60),
      .cbcd_load(ld60), .cbcd_load_lsd(ll60), .cbcd_load_msd(lm60),
      .cbcd_lsd(lsd60), .cbcd_msd(msd60), .cbcd_wrap(w60), .cbcd_load_err(e60));

   // seconds -> minutes -> hours chain
   logic       rstc = 1'b0, s_en = 1'b0, c_ld = 1'b0;
   logic [3:0] s_ll = 4'd0, m_ll = 4'd0, h_ll = 4'd0;
   logic [2:0] s_lm = 3'd0, m_lm = 3'd0, h_lm = 3'd0;
   logic [3:0] s_l, m_l, h_l;
   logic [2:0] s_m, m_m, h_m;
   logic       s_w, m_w, h_w, s_e, m_e, h_e;

   cont_bcd_mod #(.MODULO(60), .MSD_W(3)) u_sec (
      .cbcd_clock(clk), .cbcd_reset(rstc), .cbcd_en(s_en), .cbcd_up(1'b1),
      .cbcd_load(c_ld), .cbcd_load_lsd(s_ll), .cbcd_load_msd(s_lm),
      .cbcd_lsd(s_l), .cbcd_msd(s_m), .cbcd_wrap(s_w), .cbcd_load_err(s_e));
   cont_bcd_mod #(.MODULO(60), .MSD_W(3)) u_min (
      .cbcd_clock(clk), .cbcd_reset(rstc), .cbcd_en(s_w), .cbcd_up(1'b1),
      .cbcd_load(c_ld), .cbcd_load_lsd(m_ll), .cbcd_load_msd(m_lm),
      .cbcd_lsd(m_l), .cbcd_msd(m_m), .cbcd_wrap(m_w), .cbcd_load_err(m_e));
   cont_bcd_mod #(.MODULO(24), .MSD_W(3)) u_hr (
      .cbcd_clock(clk), .cbcd_reset(rstc), .cbcd_en(m_w), .cbcd_up(1'b1),
      .cbcd_load(c_ld), .cbcd_load_lsd(h_ll), .cbcd_load_msd(h_lm),
      .cbcd_lsd(h_l), .cbcd_msd(h_m), .cbcd_wrap(h_w), .cbcd_load_err(h_e));

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       nm;
   } item_t;

   item_t q[$];
   item_t mon_it;
   logic [31:0] mon_act;

   function automatic logic [31:0] v1(input int m, input int l, input bit w, input bit e);
      return {23'd0, 3'(m), 4'(l), w, e};
   endfunction

   function automatic logic [31:0] vc(input int sm, input int sl, input int mm, input int ml,
                                      input int hm, input int hl, input bit sw, input bit mw,
                                      input bit hw);
      return {5'd0, 3'(sm), 4'(sl), 3'(mm), 4'(ml), 3'(hm), 4'(hl), sw, mw, hw, 3'b000};
   endfunction

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         0:       return {23'd0, msd24, lsd24, w24, e24};
         1:       return {23'd0, msd60, lsd60, w60, e60};
         default: return {5'd0, s_m, s_l, m_m, m_l, h_m, h_l, s_w, m_w, h_w, s_e, m_e, h_e};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: each scoreboard entry describes the outputs after the next rising edge.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_it  = q.pop_front();
         mon_act = actual(mon_it.sel);
         chk(mon_it.nm, mon_act, mon_it.exp);
      end
   end

   task automatic push(input int sel, input logic [31:0] exp, input string nm);
      item_t it;
      it.sel = sel;
      it.exp = exp;
      it.nm  = nm;
      q.push_back(it);
   endtask

   task automatic d24(input bit en, input bit up, input bit ld, input int lm, input int ll,
                      input logic [31:0] exp, input string nm);
      @(negedge clk);
      en24 = en; up24 = up; ld24 = ld; lm24 = 3'(lm); ll24 = 4'(ll);
      push(0, exp, nm);
   endtask

   task automatic d60(input bit en, input bit up, input bit ld, input int lm, input int ll,
                      input logic [31:0] exp, input string nm);
      @(negedge clk);
      en60 = en; up60 = up; ld60 = ld; lm60 = 3'(lm); ll60 = 4'(ll);
      push(1, exp, nm);
   endtask

   task automatic dc(input bit en, input bit ld, input logic [31:0] exp, input string nm);
      @(negedge clk);
      s_en = en; c_ld = ld;
      push(2, exp, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      repeat (2) @(negedge clk);
      chk("reset_state_24", actual(0), v1(0, 0, 0, 0));
      chk("reset_state_60", actual(1), v1(0, 0, 0, 0));
      rst24 = 1'b1; rst60 = 1'b1; rstc = 1'b1;

      // 24 enabled up cycles: 01..23 then 00 with wrap
      for (int k = 1; k <= 24; k++) begin
         v = k % 24;
         d24(1, 1, 0, 0, 0, v1(v / 10, v % 10, k == 24, 0), "up24");
      end

      // enable toggling from 08
      d24(0, 1, 1, 0, 8, v1(0, 8, 0, 0), "load08");
      d24(1, 1, 0, 0, 0, v1(0, 9, 0, 0), "tog_en1");
      d24(0, 1, 0, 0, 0, v1(0, 9, 0, 0), "tog_en0");
      d24(1, 1, 0, 0, 0, v1(1, 0, 0, 0), "tog_carry");
      d24(0, 1, 0, 0, 0, v1(1, 0, 0, 0), "tog_hold");

      // load range checks on MODULO=24
      d24(0, 1, 1, 2, 4, v1(1, 0, 0, 1), "load24_reject");
      d24(0, 1, 1, 1, 12, v1(1, 0, 0, 1), "load_lsd12_reject");
      d24(0, 1, 1, 2, 3, v1(2, 3, 0, 0), "load23_accept");
      d24(1, 1, 0, 0, 0, v1(0, 0, 1, 0), "wrap24_up");
      d24(1, 0, 0, 0, 0, v1(2, 3, 1, 0), "borrow24_down");
      d24(1, 1, 1, 0, 5, v1(0, 5, 0, 0), "load_beats_en");
      d24(0, 1, 0, 0, 0, v1(0, 5, 0, 0), "hold_after_load");

      // asynchronous reset mid-count at 17
      d24(0, 1, 1, 1, 7, v1(1, 7, 0, 0), "load17");
      @(negedge clk);
      en24 = 1'b1; up24 = 1'b1; ld24 = 1'b0;
      #2 rst24 = 1'b0;
      #1 chk("async_reset", actual(0), v1(0, 0, 0, 0));
      push(0, v1(0, 0, 0, 0), "reset_held");
      @(negedge clk);
      rst24 = 1'b1;
      push(0, v1(0, 1, 0, 0), "resume_after_reset");
      d24(0, 1, 0, 0, 0, v1(0, 1, 0, 0), "hold_after_resume");

      // MODULO=60
      d60(0, 1, 1, 5, 9, v1(5, 9, 0, 0), "load59");
      d60(1, 1, 0, 0, 0, v1(0, 0, 1, 0), "wrap60_up");
      d60(1, 0, 0, 0, 0, v1(5, 9, 1, 0), "borrow60_down");
      d60(0, 1, 1, 5, 0, v1(5, 0, 0, 0), "load50");
      d60(1, 0, 0, 0, 0, v1(4, 9, 0, 0), "down50_49");
      d60(0, 1, 1, 6, 0, v1(4, 9, 0, 1), "load60_reject");
      d60(1, 1, 0, 0, 0, v1(5, 0, 0, 0), "dir_up");
      d60(1, 0, 0, 0, 0, v1(4, 9, 0, 0), "dir_down");

      // chain 23:59:59 -> 00:00:00
      s_lm = 3'd5; s_ll = 4'd9; m_lm = 3'd5; m_ll = 4'd9; h_lm = 3'd2; h_ll = 4'd3;
      dc(0, 1, vc(5, 9, 5, 9, 2, 3, 0, 0, 0), "chain_load");
      dc(1, 0, vc(0, 0, 5, 9, 2, 3, 1, 0, 0), "chain_sec_wrap");
      dc(0, 0, vc(0, 0, 0, 0, 2, 3, 0, 1, 0), "chain_min_wrap");
      dc(0, 0, vc(0, 0, 0, 0, 0, 0, 0, 0, 1), "chain_hr_wrap");
      dc(0, 0, vc(0, 0, 0, 0, 0, 0, 0, 0, 0), "chain_settled");

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cont_bcd_mod.md
Name: cont_bcd_mod

Overview:
- Parametrised two-digit BCD modulo counter; the general successor to the fixed 0–23 hour counter in the clock datapath.
- Instantiated as the seconds, minutes and hours counter (MODULO 60/60/24), chained through a registered wrap pulse.
- Adds up/down counting, parallel load with range checking, and wrap/borrow and error flags.

Parameters:
- MODULO, 24, count range 0..MODULO-1. Legal range 2..10*(2**MSD_W); elaboration-time error outside it.
- MSD_W, 3, width of the tens digit.
- Derived, not overridable:
  - TOP_MSD = (MODULO-1)/10
  - TOP_LSD = (MODULO-1)%10

Ports:
- cbcd_clock  in  1  clock, rising edge.
- cbcd_reset  in  1  asynchronous reset, active-low.
- cbcd_en  in  1  count enable, sampled each rising edge.
- cbcd_up  in  1  direction: 1 = increment, 0 = decrement.
- cbcd_load  in  1  parallel load request.
- cbcd_load_lsd  in  4  load value, units digit.
- cbcd_load_msd  in  MSD_W  load value, tens digit.
- cbcd_lsd  out  4  units digit (registered).
- cbcd_msd  out  MSD_W  tens digit (registered).
- cbcd_wrap  out  1  one-cycle pulse on modulo wrap or borrow (registered).
- cbcd_load_err  out  1  one-cycle pulse on a rejected load (registered).

Behaviour:
- Reset: cbcd_reset low forces cbcd_lsd=0, cbcd_msd=0, cbcd_wrap=0, cbcd_load_err=0 immediately, without waiting for a clock edge. Reset asserted mid-count aborts the count with no pulses. The first edge after deassertion acts normally.
- Per rising edge, priority is load > count > hold.
- Load (cbcd_load=1, cbcd_en ignored):
  - Valid when load_lsd<=9 and 10*load_msd+load_lsd <= MODULO-1. The digits take the load value; wrap=0; load_err=0.
  - Invalid: count unchanged; load_err=1 for exactly one cycle; wrap=0.
- Count up (load=0, en=1, up=1):
  - At (TOP_MSD,TOP_LSD): next value (0,0); wrap=1.
  - Else if lsd==9: lsd=0, msd=msd+1.
  - Else: lsd=lsd+1.
- Count down (load=0, en=1, up=0):
  - At (0,0): next value (TOP_MSD,TOP_LSD); wrap=1 (borrow).
  - Else if lsd==0: lsd=9, msd=msd-1.
  - Else: lsd=lsd-1.
- Hold (load=0, en=0): digits unchanged; wrap=0; load_err=0.
- wrap and load_err are registered. Each is high only in the cycle following the edge that caused it, aligned with the wrapped or unchanged digit values. They are never high simultaneously.
- Latency: one clock from the input sample to the new digit values.
- Invariant: lsd<=9 and value<=MODULO-1 at all times after reset. No illegal BCD state is reachable.
- Arithmetic: digit-wise only; no binary intermediate wider than 4 bits per digit. The msd increment wraps only through the modulo rule, never through MSD_W overflow.
- Chaining: the downstream en is tied to the upstream wrap, so the higher digit advances one cycle after the lower one wraps. A one-cycle skew is accepted.
- Continuous en=1 across wrap: the counter keeps counting without stalling; wrap pulses once per wrap.
- cbcd_up may change every cycle; the value sampled at the edge decides the direction.

Test Plan:
- Reset then 24 enabled up cycles (MODULO=24) -> sequence 00..09,10..19,20..23,00; wrap=1 only in the cycle showing 00; lsd 9->0 carries at 09 and 19.
- MODULO=60: load 59 valid, one up -> 00 with wrap=1; one down -> 59 with wrap=1; down from 50 -> 49 with wrap=0.
- MODULO=24 load attempts: 24 -> load_err=1, value unchanged; msd=1,lsd=12 -> load_err=1, unchanged; 23 -> accepted, load_err=0. Load with en=1 at the same edge -> load wins.
- en toggling 1,0,1,0 from 08 -> 09,09,10,10; wrap and load_err stay 0.
- Assert cbcd_reset low mid-cycle at value 17 with en=1 -> outputs 00 before the next clock edge; no wrap pulse; counting resumes from 00 after release.
- Chain seconds(60) -> minutes(60) -> hours(24), all enables from upstream wraps, start 23:59:59 -> all roll to 00:00:00 with one-cycle skew per stage; hours wrap pulses once.
